// File: rtl/clint_pkg.sv
// Shared constants for the core-local interruptor: address window, register
// offsets and the RTC divider, plus the byte-lane merge used by every register.
package clint_pkg;

  localparam logic [31:0] clint_base_addr    = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr     = clint_base_addr + 32'h0000_ffff;
  localparam int unsigned clk_divider_rtc    = 15257;

  localparam logic [31:0] clint_msip_off     = 32'h0000_0000;
  localparam logic [31:0] clint_mtimecmp_off = 32'h0000_4000;
  localparam logic [31:0] clint_mtime_off    = 32'h0000_bff8;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// RTC tick generator: divides the core clock down to the mtime increment rate.
// tick pulses for one cycle on the cycle the phase bit goes from 0 to 1.
module clint_rtc_tick #(
  parameter int unsigned clk_divider_rtc = clint_pkg::clk_divider_rtc
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned cnt_w = (clk_divider_rtc > 0) ? $clog2(clk_divider_rtc + 1) : 1;
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(clk_divider_rtc);

  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             wrap;

  always_comb begin
    wrap    = (cnt_q == cnt_max);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    phase_d = wrap ? ~phase_q : phase_q;
  end

  assign tick = wrap & ~phase_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip / mtimecmp / mtime register block on the data bus,
// with a registered one-cycle response and a registered timer-interrupt compare.
module clint #(
  parameter int unsigned rtc_divider = clint_pkg::clk_divider_rtc
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);
  import clint_pkg::*;

  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d, ready_q, ready_d, mtip_q, mtip_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] off, rd_val;
  logic        tick, in_window, wr;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic        unused_ok;

  clint_rtc_tick #(.clk_divider_rtc(rtc_divider)) u_rtc_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    off         = clint_addr - clint_base_addr;
    in_window   = (clint_addr >= clint_base_addr) && (clint_addr <= clint_top_addr);
    sel_msip    = in_window && (off[15:2] == clint_msip_off[15:2]);
    sel_cmp_lo  = in_window && (off[15:2] == clint_mtimecmp_off[15:2]);
    sel_cmp_hi  = in_window && (off[15:2] == clint_mtimecmp_off[15:2] + 14'd1);
    sel_time_lo = in_window && (off[15:2] == clint_mtime_off[15:2]);
    sel_time_hi = in_window && (off[15:2] == clint_mtime_off[15:2] + 14'd1);
    wr          = clint_valid && (clint_wstrb != 4'b0000);

    rd_val = '0;
    if (sel_msip)         rd_val = {31'b0, msip_q};
    else if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
    else if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
    else if (sel_time_lo) rd_val = mtime_q[31:0];
    else if (sel_time_hi) rd_val = mtime_q[63:32];

    // A write to either mtime half overrides the tick: the untouched bytes keep
    // their pre-increment value and no carry propagates.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && sel_time_lo)
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
    if (wr && sel_time_hi)
      mtime_d = {merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};

    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo)
      mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb)};
    if (wr && sel_cmp_hi)
      mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb), mtimecmp_q[31:0]};

    msip_d = msip_q;
    if (wr && sel_msip && clint_wstrb[0]) msip_d = clint_wdata[0];

    ready_d = clint_valid;
    rdata_d = (clint_valid && !wr) ? rd_val : 32'h0;
    mtip_d  = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      mtip_q     <= mtip_d;
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = ready_q;
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;
  assign clint_mtime = mtime_q;

  assign unused_ok = ^{clint_instr, off[31:16], off[1:0]};

endmodule
